// File: rtl/seq_det_pkg.sv
`default_nettype none
// seq_det_pkg: reset pattern/length and width helpers for seq_detect_arbiter.
// Rev 1.0
package seq_det_pkg;

  localparam logic [2:0] RST_PATTERN = 3'b110;
  localparam int         RST_LEN     = 3;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: round-robin, one-hot grant; pointer moves to the winner on advance.
// Rev 1.0
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] r_ptr;
  logic            w_found;

  // Search begins just after the last winner, so it becomes lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % NUM_CH;
      if (!w_found && req[idx]) begin
        w_found    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= CH_W'(NUM_CH - 1);
    end else if (advance && w_found) begin
      r_ptr <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_arbiter.sv
`default_nettype none
// seq_detect_arbiter: one pattern detector time-shared over NUM_CH serial streams.
// Optional per-channel match counters: SEQ_DET_MATCH_CNT_EN.  Rev 1.0
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int PAT_W  = 8,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = ch_w(NUM_CH),
  localparam int LW     = len_w(PAT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_rd_data
);

  logic [PAT_W-1:0] r_hist [NUM_CH];
  logic [LW-1:0]    r_fill [NUM_CH];
  logic [PAT_W-1:0] r_pattern;
  logic [LW-1:0]    r_len;
  logic             r_match_valid;
  logic [CH_W-1:0]  r_match_ch;

  logic [NUM_CH-1:0] w_req;
  logic [CH_W-1:0]   w_gidx;
  logic              w_xfer;
  logic              w_bit;
  logic [PAT_W:0]    w_cat;
  logic [PAT_W:0]    w_mask;
  logic              w_match;

  // No grants while reconfiguring or in reset, so no bit is consumed then.
  assign w_req = (reset || cfg_we) ? '0 : ch_valid;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (w_req),
    .advance   (w_xfer),
    .grant     (ch_ready),
    .grant_idx (w_gidx)
  );

  always_comb begin
    w_xfer  = |ch_ready;
    w_bit   = ch_bit[w_gidx];
    w_cat   = {r_hist[w_gidx], w_bit};
    w_mask  = '0;
    w_match = 1'b0;
    for (int b = 0; b <= PAT_W; b++) begin
      w_mask[b] = (b < int'(r_len));
    end
    if (w_xfer && (r_len != '0) &&
        (({1'b0, r_fill[w_gidx]} + 1'b1) >= {1'b0, r_len}) &&
        (((w_cat ^ {1'b0, r_pattern}) & w_mask) == '0)) begin
      w_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern     <= PAT_W'(RST_PATTERN);
      r_len         <= LW'(RST_LEN);
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= '0;
        r_fill[c] <= '0;
      end
    end else if (cfg_we) begin
      r_pattern     <= cfg_pattern;
      r_len         <= (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
      r_match_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= '0;
        r_fill[c] <= '0;
      end
    end else begin
      r_match_valid <= w_match;
      if (w_match) begin
        r_match_ch <= w_gidx;
      end
      if (w_xfer) begin
        r_hist[w_gidx] <= w_cat[PAT_W-1:0];
        if (r_fill[w_gidx] != LW'(PAT_W)) begin
          r_fill[w_gidx] <= r_fill[w_gidx] + 1'b1;
        end
      end
    end
  end

  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  // Clear takes priority over a same-cycle match.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
      end
    end else if (w_match && (r_cnt[w_gidx] != {CNT_W{1'b1}})) begin
      r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
    end
  end

  assign cnt_rd_data = (int'(cnt_sel) < NUM_CH) ? r_cnt[cnt_sel] : '0;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^{cnt_clr, cnt_sel};
  assign cnt_rd_data  = '0;
`endif

endmodule
`default_nettype wire
